// File: rtl/digit_detect.sv
// Argmax stage for the output layer: scans the sigmoid register file after a
// network_done pulse and holds digit, confidence and tie until acknowledged.
module digit_detect #(
    parameter int FIRST_ADDR  = 8,
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 4,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              network_done,
    input  logic [DATA_W-1:0] sigmoid_data,
    output logic              read_en,
    output logic [ADDR_W-1:0] read_addr,
    output logic              busy,
    output logic [3:0]        digit,
    output logic [DATA_W-1:0] confidence,
    output logic              tie,
    output logic              digit_valid,
    input  logic              digit_ack
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        VALID
    } state_t;

    localparam logic [3:0]        LAST_IDX  = 4'(NUM_CLASSES - 1);
    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(FIRST_ADDR);

    state_t            state;
    logic [3:0]        idx;

    logic              cmp_vld_p0;
    logic [3:0]        cmp_idx_p0;

    logic [DATA_W-1:0] best_val;
    logic [3:0]        best_idx;
    logic              tie_acc;

    logic [DATA_W-1:0] best_val_nxt;
    logic [3:0]        best_idx_nxt;
    logic              tie_nxt;

    // Compare stage: datum for cmp_idx_p0 arrives one cycle after its read
    always_comb begin
        best_val_nxt = best_val;
        best_idx_nxt = best_idx;
        tie_nxt      = tie_acc;
        if (cmp_vld_p0) begin
            if (cmp_idx_p0 == 4'd0) begin
                best_val_nxt = sigmoid_data;
                best_idx_nxt = 4'd0;
                tie_nxt      = 1'b0;
            end else if (sigmoid_data > best_val) begin
                best_val_nxt = sigmoid_data;
                best_idx_nxt = cmp_idx_p0;
                tie_nxt      = 1'b0;
            end else if (sigmoid_data == best_val) begin
                tie_nxt      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            idx         <= 4'd0;
            read_en     <= 1'b0;
            read_addr   <= '0;
            busy        <= 1'b0;
            digit       <= 4'd0;
            confidence  <= '0;
            tie         <= 1'b0;
            digit_valid <= 1'b0;
            best_idx    <= 4'd0;
            best_val    <= '0;
            tie_acc     <= 1'b0;
            cmp_vld_p0  <= 1'b0;
            cmp_idx_p0  <= 4'd0;
        end else begin
            cmp_vld_p0 <= read_en;
            cmp_idx_p0 <= idx;
            best_val   <= best_val_nxt;
            best_idx   <= best_idx_nxt;
            tie_acc    <= tie_nxt;

            case (state)
                IDLE: begin
                    read_en <= 1'b0;
                    if (network_done) begin
                        state     <= SCAN;
                        idx       <= 4'd0;
                        read_en   <= 1'b1;
                        read_addr <= BASE_ADDR;
                        busy      <= 1'b1;
                    end
                end
                SCAN: begin
                    if (idx == LAST_IDX) begin
                        state   <= DRAIN;
                        read_en <= 1'b0;
                    end else begin
                        idx       <= idx + 4'd1;
                        read_addr <= BASE_ADDR + ADDR_W'(idx + 4'd1);
                    end
                end
                DRAIN: begin
                    // The last datum is folded in on this same edge
                    digit       <= best_idx_nxt;
                    confidence  <= best_val_nxt;
                    tie         <= tie_nxt;
                    digit_valid <= 1'b1;
                    busy        <= 1'b0;
                    state       <= VALID;
                end
                VALID: begin
                    if (network_done) begin
                        state       <= SCAN;
                        idx         <= 4'd0;
                        read_en     <= 1'b1;
                        read_addr   <= BASE_ADDR;
                        busy        <= 1'b1;
                        digit_valid <= 1'b0;
                    end else if (digit_ack) begin
                        state       <= IDLE;
                        digit_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_detect.sv
// Directed bench for digit_detect with a registered sigmoid register file model.
module tb_digit_detect;

    typedef logic [3:0] vec_t [10];

    logic       clk = 1'b0;
    logic       n_rst;
    logic       network_done;
    logic [3:0] sigmoid_data;
    logic       read_en;
    logic [4:0] read_addr;
    logic       busy;
    logic [3:0] digit;
    logic [3:0] confidence;
    logic       tie;
    logic       digit_valid;
    logic       digit_ack;

    logic [3:0] mem [32];
    int checks = 0;
    int errors = 0;

    digit_detect #(
        .FIRST_ADDR (8),
        .NUM_CLASSES(10),
        .DATA_W     (4),
        .ADDR_W     (5)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .network_done(network_done),
        .sigmoid_data(sigmoid_data),
        .read_en     (read_en),
        .read_addr   (read_addr),
        .busy        (busy),
        .digit       (digit),
        .confidence  (confidence),
        .tie         (tie),
        .digit_valid (digit_valid),
        .digit_ack   (digit_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (read_en) sigmoid_data <= mem[read_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < 10; i++) mem[8 + i] = v[i];
    endtask

    // Cycle 0 is the cycle network_done is high; samples are taken at negedge.
    task automatic run_scan(input vec_t v, input int exp_digit, input int exp_conf,
                            input int exp_tie, input int extra_cycle, input bit restart,
                            input int held_digit);
        load(v);
        @(negedge clk);
        network_done = 1'b1;
        if (restart) digit_ack = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                network_done = 1'b0;
                digit_ack    = 1'b0;
            end
            check("read_en", 32'(read_en), 32'(c <= 10));
            if (c <= 10) check("read_addr", 32'(read_addr), 32'(8 + c - 1));
            check("busy", 32'(busy), 32'(c <= 11));
            check("digit_valid", 32'(digit_valid), 32'(c == 12));
            if (c < 12) check("held_digit", 32'(digit), 32'(held_digit));
            if (extra_cycle != 0 && c == extra_cycle) begin
                network_done = 1'b1;
                digit_ack    = 1'b1;
            end else if (extra_cycle != 0 && c == extra_cycle + 1) begin
                network_done = 1'b0;
                digit_ack    = 1'b0;
            end
        end
        check("digit", 32'(digit), 32'(exp_digit));
        check("confidence", 32'(confidence), 32'(exp_conf));
        check("tie", 32'(tie), 32'(exp_tie));
    endtask

    task automatic do_ack(input int exp_digit);
        @(negedge clk);
        digit_ack = 1'b1;
        @(negedge clk);
        digit_ack = 1'b0;
        check("ack_valid_drop", 32'(digit_valid), 32'd0);
        check("ack_digit_held", 32'(digit), 32'(exp_digit));
        check("ack_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t va, vb, vc, vz, v9, vd;
        va = '{4'd1, 4'd3, 4'd2, 4'd0, 4'd4, 4'd5, 4'd6, 4'd15, 4'd2, 4'd1};
        vb = '{4'd0, 4'd0, 4'd12, 4'd3, 4'd3, 4'd12, 4'd1, 4'd0, 4'd0, 4'd0};
        vc = '{4'd0, 4'd0, 4'd12, 4'd3, 4'd3, 4'd12, 4'd13, 4'd0, 4'd0, 4'd0};
        vd = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd2, 4'd6, 4'd5, 4'd3};
        for (int i = 0; i < 10; i++) begin
            vz[i] = 4'd0;
            v9[i] = 4'd9;
        end
        for (int i = 0; i < 32; i++) mem[i] = 4'd0;

        n_rst        = 1'b0;
        network_done = 1'b0;
        digit_ack    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_read_en", 32'(read_en), 32'd0);
        check("rst_read_addr", 32'(read_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_digit", 32'(digit), 32'd0);
        check("rst_conf", 32'(confidence), 32'd0);
        check("rst_tie", 32'(tie), 32'd0);
        check("rst_valid", 32'(digit_valid), 32'd0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        run_scan(va, 7, 15, 0, 0, 1'b0, 0);

        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (i % 10 == 0) begin
                check("stable_valid", 32'(digit_valid), 32'd1);
                check("stable_digit", 32'(digit), 32'd7);
                check("stable_conf", 32'(confidence), 32'd15);
            end
        end
        do_ack(7);

        @(negedge clk);
        digit_ack = 1'b1;
        @(negedge clk);
        digit_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_read_en", 32'(read_en), 32'd0);
        check("idle_ack_busy", 32'(busy), 32'd0);
        check("idle_ack_valid", 32'(digit_valid), 32'd0);

        run_scan(vb, 2, 12, 1, 0, 1'b0, 7);
        do_ack(2);
        run_scan(vc, 6, 13, 0, 0, 1'b0, 2);
        do_ack(6);
        run_scan(vz, 0, 0, 1, 0, 1'b0, 6);
        do_ack(0);
        run_scan(v9, 0, 9, 1, 0, 1'b0, 0);
        do_ack(0);

        run_scan(va, 7, 15, 0, 5, 1'b0, 0);
        run_scan(vd, 5, 9, 0, 0, 1'b1, 7);

        @(negedge clk);
        network_done = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) network_done = 1'b0;
        end
        n_rst = 1'b0;
        #1;
        check("arst_read_en", 32'(read_en), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(digit_valid), 32'd0);
        check("arst_digit", 32'(digit), 32'd0);
        check("arst_conf", 32'(confidence), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle_busy", 32'(busy), 32'd0);
        check("post_rst_idle_valid", 32'(digit_valid), 32'd0);

        run_scan(va, 7, 15, 0, 0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
